// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter driving a shared 2-to-4 decoder.
// Registered grant index, one-hot grant, and bounded-tenure preemption.
module rr_decoder_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] gidx,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } pick_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  state_t        state_q, state_d;
  logic [1:0]    gidx_q, gidx_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          preempt_q, preempt_d;
  logic [3:0]    gnt_q, gnt_d;

  logic [3:0]    owner_hot;
  logic [3:0]    others;
  pick_t         pick_all;
  pick_t         pick_oth;

  // Rotate so bit 0 is the pointer slot, then take the lowest set bit.
  function automatic pick_t rr_pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    pick_t      res;
    dbl = {r, r};
    rot = dbl[p +: 4];
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    res.hit = |r;
    res.idx = p + off;
    return res;
  endfunction

  always_comb begin
    owner_hot = 4'b0001 << gidx_q;
    others    = req & ~owner_hot;
    pick_all  = rr_pick(req, ptr_q);
    pick_oth  = rr_pick(others, ptr_q);
  end

  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pick_all.hit) begin
          state_d = GRANT;
          gidx_d  = pick_all.idx;
          ptr_d   = pick_all.idx + 2'd1;
          cnt_d   = '0;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (!req[gidx_q]) begin
          if (pick_oth.hit) begin
            gidx_d = pick_oth.idx;
            ptr_d  = pick_oth.idx + 2'd1;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else if (cnt_q == HOLD_LAST && pick_oth.hit) begin
          gidx_d    = pick_oth.idx;
          ptr_d     = pick_oth.idx + 2'd1;
          cnt_d     = '0;
          preempt_d = 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    gnt_d = 4'b0000;
    if (valid_d) begin
      unique case (gidx_d)
        2'd0: gnt_d = 4'b0001;
        2'd1: gnt_d = 4'b0010;
        2'd2: gnt_d = 4'b0100;
        2'd3: gnt_d = 4'b1000;
        default: gnt_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gidx_q    <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      gnt_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gidx    = gidx_q;
  assign gnt     = gnt_q;
  assign valid   = valid_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter.
// A tenure-counting model queues expected outputs per edge.
module tb_rr_decoder_arbiter;

  localparam int HOLD_MAX = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] gidx;
  logic [3:0] gnt;
  logic       valid;
  logic       preempt;

  rr_decoder_arbiter #(
    .HOLD_MAX(HOLD_MAX),
    .CW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gidx(gidx),
    .gnt(gnt),
    .valid(valid),
    .preempt(preempt)
  );

  typedef struct {
    logic [1:0] gidx;
    logic [3:0] gnt;
    logic       valid;
    logic       pre;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  logic       m_valid = 1'b0;
  logic [1:0] m_gidx = 2'd0;
  logic [1:0] m_ptr = 2'd0;
  logic       m_pre = 1'b0;
  int         m_ten = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = p + k[1:0];
      if (r[idx]) return int'(idx);
    end
    return -1;
  endfunction

  task automatic take(input int p);
    m_gidx = p[1:0];
    m_ptr  = m_gidx + 2'd1;
    m_ten  = 1;
  endtask

  task automatic model(
    input logic       r,
    input logic [3:0] rq
  );
    int p;
    logic [3:0] oth;
    m_pre = 1'b0;
    if (r) begin
      m_valid = 1'b0;
      m_gidx  = 2'd0;
      m_ptr   = 2'd0;
      m_ten   = 0;
    end else if (!m_valid) begin
      p = pick(rq, m_ptr);
      if (p >= 0) begin
        take(p);
        m_valid = 1'b1;
      end
    end else begin
      oth = rq;
      oth[m_gidx] = 1'b0;
      p = pick(oth, m_ptr);
      if (!rq[m_gidx]) begin
        if (p >= 0) take(p);
        else m_valid = 1'b0;
      end else if (p >= 0 && m_ten >= HOLD_MAX) begin
        take(p);
        m_pre = 1'b1;
      end else if (m_ten < HOLD_MAX) begin
        m_ten++;
      end
    end
  endtask

  task automatic step(
    input logic       r,
    input logic [3:0] rq
  );
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = r;
    req = rq;
    model(r, rq);
    e.gidx  = m_gidx;
    e.gnt   = m_valid ? (4'b0001 << m_gidx) : 4'b0000;
    e.valid = m_valid;
    e.pre   = m_pre;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      chk("sb_gidx", 32'(gidx), 32'(g.gidx));
      chk("sb_gnt", 32'(gnt), 32'(g.gnt));
      chk("sb_valid", 32'(valid), 32'(g.valid));
      chk("sb_preempt", 32'(preempt), 32'(g.pre));
    end
  endtask

  logic [3:0] order[$];
  logic [3:0] exp_ord [5];
  logic [3:0] last;
  logic [3:0] rq;
  int         n;

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset with all requesting
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'b1111);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_gidx", 32'(gidx), 32'h0);
    end
    step(1'b0, 4'b1111);
    chk("first_gnt", 32'(gnt), 32'h1);

    // single requester
    step(1'b1, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0100);
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_pre", 32'(preempt), 32'h0);
    end
    step(1'b0, 4'b0000);
    chk("single_drop_gnt", 32'(gnt), 32'h0);
    chk("single_drop_valid", 32'(valid), 32'h0);

    // rotation with release after 2 cycles
    step(1'b1, 4'b0000);
    last = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      rq = 4'b1111;
      if (m_valid && m_ten == 2) rq[m_gidx] = 1'b0;
      step(1'b0, rq);
      chk("rot_nogap", 32'(gnt != 4'b0000), 32'h1);
      if (gnt != last && gnt != 4'b0000) order.push_back(gnt);
      last = gnt;
    end
    chk("rot_len", 32'(order.size() >= 5), 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size())
        chk("rot_order", 32'(order[i]), 32'(exp_ord[i]));
    end

    // preemption under constant contention
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0011);
    n = 1;
    for (int i = 0; i < 20 && gnt == 4'b0001; i++) begin
      step(1'b0, 4'b0011);
      if (gnt == 4'b0001) n++;
    end
    chk("tenure0", 32'(n), 32'(HOLD_MAX));
    chk("pre0_gnt", 32'(gnt), 32'h2);
    chk("pre0_pulse", 32'(preempt), 32'h1);
    for (int i = 0; i < HOLD_MAX - 1; i++) step(1'b0, 4'b0011);
    chk("tenure1_hold", 32'(gnt), 32'h2);
    chk("tenure1_nopre", 32'(preempt), 32'h0);
    step(1'b0, 4'b0011);
    chk("pre1_gnt", 32'(gnt), 32'h1);
    chk("pre1_pulse", 32'(preempt), 32'h1);

    // release exactly at the hold limit
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0011);
    for (int i = 0; i < HOLD_MAX - 1; i++) step(1'b0, 4'b0011);
    chk("lim_owner", 32'(gnt), 32'h1);
    step(1'b0, 4'b0010);
    chk("lim_gnt", 32'(gnt), 32'h2);
    chk("lim_pre", 32'(preempt), 32'h0);

    // wrap 3 -> 0, then reset mid-grant
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1000);
    chk("wrap_g3", 32'(gidx), 32'h3);
    for (int i = 0; i < HOLD_MAX - 1; i++) step(1'b0, 4'b1001);
    chk("wrap_hold3", 32'(gnt), 32'h8);
    step(1'b0, 4'b1001);
    chk("wrap_g0", 32'(gnt), 32'h1);
    chk("wrap_gidx0", 32'(gidx), 32'h0);
    step(1'b1, 4'b1001);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    step(1'b0, 4'b0010);
    chk("postrst_gnt", 32'(gnt), 32'h2);

    // ptr restarts at 0: 1001 must pick index 0
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1001);
    chk("ptr0_pick", 32'(gnt), 32'h1);

    // random traffic against the model
    step(1'b1, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)));
      chk("rand_onehot", 32'($countones(gnt) <= 1), 32'h1);
    end

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
